multicycle_controller: RTL and testbench

- Main control FSM for the multicycle RV32I core.
- Sequences the shared datapath each instruction: one memory port, one ALU, and the immediate generator.
- Drives mux selects, write strobes, `alu_control_o` and `imm_src_o` from the instruction register contents, the ALU zero flag and a memory ready handshake.
- Sits between the instruction register and the datapath. It is the only block that drives the immediate generator's select; that select is widened to 3 bits.

---
 rtl/multicycle_controller.sv | 265 ++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences the shared memory
// port, ALU and immediate generator from the instruction register contents.
module multicycle_controller (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] instr_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_write_o,
  output logic        adr_src_o,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic        pc_lsb_clr_o,
  output logic        reg_write_o,
  output logic [1:0]  result_src_o,
  output logic [1:0]  alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [3:0]  alu_control_o,
  output logic [2:0]  imm_src_o,
  output logic        illegal_o,
  output logic [3:0]  state_o
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC <= PC+4 on completion
  // DECODE   | ALUOut <= OldPC + imm (branch/jump target), dispatch on opcode
  // MEMADR   | ALUOut <= rs1 + imm (load/store address)
  // MEMREAD  | load request at ALUOut, hold until ready
  // MEMWB    | rd <= read data
  // MEMWRITE | store request at ALUOut, hold until ready
  // EXECR    | ALUOut <= rs1 op rs2
  // EXECI    | ALUOut <= rs1 op imm
  // ALUWB    | rd <= ALUOut
  // BRANCH   | compare rs1/rs2, PC <= ALUOut when taken
  // JAL      | PC <= ALUOut, ALUOut <= OldPC+4
  // JALR     | ALUOut <= rs1 + imm
  // JALR_PC  | PC <= ALUOut with bit 0 cleared, ALUOut <= OldPC+4
  // LUI      | ALUOut <= imm
  // AUIPC    | ALUOut <= OldPC + imm
  // TRAP     | illegal instruction, left only through reset

  localparam int INSTR_WIDTH = 32;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALR_PC  = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_AND    = 4'b0010;
  localparam logic [3:0] ALU_OR     = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_SLT    = 4'b0101;
  localparam logic [3:0] ALU_SLTU   = 4'b0110;
  localparam logic [3:0] ALU_SLL    = 4'b0111;
  localparam logic [3:0] ALU_SRL    = 4'b1000;
  localparam logic [3:0] ALU_SRA    = 4'b1001;
  localparam logic [3:0] ALU_PASS_B = 4'b1010;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t     state_q, state_d;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       r_legal;
  logic       b_legal;
  logic       mem_req, mem_write, ir_write, pc_write, pc_lsb_clr, reg_write, illegal;
  logic       unused_instr_bits;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[INSTR_WIDTH-1:25];
  assign unused_instr_bits = ^{instr_i[24:15], instr_i[11:7]};

  assign r_legal = (funct7 == 7'b0000000) ||
                   ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
  assign b_legal = (funct3 == 3'b000) || (funct3 == 3'b001);

  // alt selects SUB on funct3 000 and SRA on funct3 101
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_lsb_clr    = 1'b0;
    reg_write     = 1'b0;
    illegal       = 1'b0;
    adr_src_o     = 1'b0;
    result_src_o  = 2'b00;
    alu_src_a_o   = 2'b00;
    alu_src_b_o   = 2'b00;
    alu_control_o = ALU_ADD;
    imm_src_o     = IMM_I;
    case (state_q)
      S_FETCH: begin
        mem_req      = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        if (mem_ready_i) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        imm_src_o   = (opcode == OP_JAL) ? IMM_J : IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = r_legal ? S_EXECR : S_TRAP;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = b_legal ? S_BRANCH : S_TRAP;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        imm_src_o   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_d     = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req   = 1'b1;
        adr_src_o = 1'b1;
        if (mem_ready_i) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_o = 2'b01;
        reg_write    = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src_o = 1'b1;
        if (mem_ready_i) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a_o   = 2'b10;
        alu_control_o = alu_dec(funct3, funct7[5]);
        state_d       = S_ALUWB;
      end
      S_EXECI: begin
        // addi has no subtract form, so funct7[5] only matters for shifts
        alu_src_a_o   = 2'b10;
        alu_src_b_o   = 2'b01;
        alu_control_o = alu_dec(funct3, funct7[5] && (funct3 == 3'b101));
        state_d       = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o   = 2'b10;
        alu_control_o = ALU_SUB;
        pc_write      = ((funct3 == 3'b000) && zero_i) || ((funct3 == 3'b001) && !zero_i);
        state_d       = S_FETCH;
      end
      S_JAL: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_write    = 1'b1;
        state_d     = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        state_d     = S_JALR_PC;
      end
      S_JALR_PC: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_write    = 1'b1;
        pc_lsb_clr  = 1'b1;
        state_d     = S_ALUWB;
      end
      S_LUI: begin
        alu_src_b_o   = 2'b01;
        imm_src_o     = IMM_U;
        alu_control_o = ALU_PASS_B;
        state_d       = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        imm_src_o   = IMM_U;
        state_d     = S_ALUWB;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: state_d = S_TRAP;
    endcase
  end

  // Strobes are gated by reset directly; the state register already sits in
  // FETCH during reset, so the selects show the FETCH values.
  assign mem_req_o    = mem_req    & rst_ni;
  assign mem_write_o  = mem_write  & rst_ni;
  assign ir_write_o   = ir_write   & rst_ni;
  assign pc_write_o   = pc_write   & rst_ni;
  assign pc_lsb_clr_o = pc_lsb_clr & rst_ni;
  assign reg_write_o  = reg_write  & rst_ni;
  assign illegal_o    = illegal    & rst_ni;
  assign state_o      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed vector table,
// reset corner sequences and randomized instructions against a path model.
module tb_multicycle_controller;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] instr_i = 32'h0;
  logic        zero_i = 1'b0;
  logic        mem_ready_i = 1'b0;
  logic        mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o;
  logic        pc_lsb_clr_o, reg_write_o, illegal_o;
  logic [1:0]  result_src_o, alu_src_a_o, alu_src_b_o;
  logic [3:0]  alu_control_o, state_o;
  logic [2:0]  imm_src_o;

  multicycle_controller dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .instr_i(instr_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_write_o(mem_write_o),
    .adr_src_o(adr_src_o), .ir_write_o(ir_write_o), .pc_write_o(pc_write_o),
    .pc_lsb_clr_o(pc_lsb_clr_o), .reg_write_o(reg_write_o),
    .result_src_o(result_src_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .alu_control_o(alu_control_o),
    .imm_src_o(imm_src_o), .illegal_o(illegal_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       req, wr, adr, irw, pcw, lsb, regw;
    logic [1:0] res, a, b;
    logic [3:0] alu;
    logic [2:0] imm;
    logic       ill;
  } out_t;

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        zero, ready;
    logic [3:0]  st;
    out_t        o;
  } vec_t;

  out_t dut_o;
  assign dut_o = {mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o,
                  pc_lsb_clr_o, reg_write_o, result_src_o, alu_src_a_o,
                  alu_src_b_o, alu_control_o, imm_src_o, illegal_o};

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'h0040A183;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_JALR = 32'h000080E7;
  localparam logic [31:0] I_LUI  = 32'h123450B7;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                         OP_R = 7'b0110011, OP_I = 7'b0010011,
                         OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111,
                         OP_AUIPC = 7'b0010111;

  int   n_checks = 0;
  int   n_fail = 0;
  int   seq[$];
  logic [3:0] alu_base [8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
  out_t rst_o;

  task automatic check(input string name, input logic [3:0] st, input out_t o);
    n_checks++;
    if (state_o !== st || dut_o !== o) begin
      n_fail++;
      $display("FAIL %s: got state=%0d out=%h, expected state=%0d out=%h (t=%0t)",
               name, state_o, dut_o, st, o, $time);
    end
  endtask

  function automatic vec_t v(input logic rst, input logic [31:0] ins, input logic z,
                             input logic r, input int st, input logic req, input logic wr,
                             input logic adr, input logic irw, input logic pcw,
                             input logic lsb, input logic regw, input int res,
                             input int a, input int b, input int alu, input int imm);
    vec_t t;
    t.rst = rst; t.instr = ins; t.zero = z; t.ready = r; t.st = 4'(st);
    t.o = '0;
    t.o.req = req; t.o.wr = wr; t.o.adr = adr; t.o.irw = irw; t.o.pcw = pcw;
    t.o.lsb = lsb; t.o.regw = regw; t.o.res = 2'(res); t.o.a = 2'(a);
    t.o.b = 2'(b); t.o.alu = 4'(alu); t.o.imm = 3'(imm);
    return t;
  endfunction

  // Instruction class: 0 load 1 store 2 R 3 I 4 branch 5 jal 6 jalr 7 lui 8 auipc 9 trap
  function automatic int class_of(input logic [31:0] w);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12];
    f7 = w[31:25];
    case (w[6:0])
      OP_LOAD:  return 0;
      OP_STORE: return 1;
      OP_R:     return (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) ? 2 : 9;
      OP_I:     return 3;
      OP_BR:    return (f3 < 3'd2) ? 4 : 9;
      OP_JAL:   return 5;
      OP_JALR:  return 6;
      OP_LUI:   return 7;
      OP_AUIPC: return 8;
      default:  return 9;
    endcase
  endfunction

  task automatic fill_seq(input int c);
    case (c)
      0: seq = '{0, 1, 2, 3, 4};
      1: seq = '{0, 1, 2, 5};
      2: seq = '{0, 1, 6, 8};
      3: seq = '{0, 1, 7, 8};
      4: seq = '{0, 1, 9};
      5: seq = '{0, 1, 10, 8};
      6: seq = '{0, 1, 11, 12, 8};
      7: seq = '{0, 1, 13, 8};
      8: seq = '{0, 1, 14, 8};
      default: seq = '{0, 1, 15};
    endcase
  endtask

  function automatic logic [3:0] alu_of(input logic [31:0] w, input bit is_r);
    bit alt;
    alt = w[30] && (w[14:12] == 3'd5 || (is_r && w[14:12] == 3'd0));
    return alu_base[w[14:12]] + (alt ? 4'd1 : 4'd0);
  endfunction

  function automatic out_t exp_out(input int st, input logic [31:0] w, input logic z,
                                   input logic r);
    out_t o;
    o = '0;
    case (st)
      0:  begin o.req = 1; o.b = 2; o.res = 2; o.irw = r; o.pcw = r; end
      1:  begin o.a = 1; o.b = 1; o.imm = (w[6:0] == OP_JAL) ? 3'd4 : 3'd2; end
      2:  begin o.a = 2; o.b = 1; o.imm = (w[6:0] == OP_STORE) ? 3'd1 : 3'd0; end
      3:  begin o.req = 1; o.adr = 1; end
      4:  begin o.res = 1; o.regw = 1; end
      5:  begin o.req = 1; o.wr = 1; o.adr = 1; end
      6:  begin o.a = 2; o.alu = alu_of(w, 1'b1); end
      7:  begin o.a = 2; o.b = 1; o.alu = alu_of(w, 1'b0); end
      8:  o.regw = 1;
      9:  begin o.a = 2; o.alu = 1; o.pcw = (w[14:12] == 3'd0) ? z : !z; end
      10: begin o.a = 1; o.b = 2; o.pcw = 1; end
      11: begin o.a = 2; o.b = 1; end
      12: begin o.a = 1; o.b = 2; o.pcw = 1; o.lsb = 1; end
      13: begin o.b = 1; o.imm = 3; o.alu = 10; end
      14: begin o.a = 1; o.b = 1; o.imm = 3; end
      default: o.ill = 1;
    endcase
    return o;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 10))
      0: w[6:0] = OP_LOAD;
      1: w[6:0] = OP_STORE;
      2: begin
        w[6:0] = OP_R;
        case ($urandom_range(0, 2))
          0: w[31:25] = 7'h00;
          1: begin w[31:25] = 7'h20; w[14:12] = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'd5; end
          default: ;
        endcase
      end
      3: w[6:0] = OP_I;
      4: begin
        w[6:0] = OP_BR;
        if ($urandom_range(0, 3) != 0) w[14:12] = 3'($urandom_range(0, 1));
      end
      5: w[6:0] = OP_JAL;
      6: w[6:0] = OP_JALR;
      7: w[6:0] = OP_LUI;
      8: w[6:0] = OP_AUIPC;
      default: ;
    endcase
    return w;
  endfunction

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_o = '0; rst_o.b = 2; rst_o.res = 2;

    //       rst instr  z r  st req wr adr irw pcw lsb regw res a b alu imm
    tbl.push_back(v(0, I_ADD, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0));
    tbl.push_back(v(0, I_ADD, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0));
    tbl.push_back(v(1, I_ADD, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0, 2, 0, 2, 0, 0));
    tbl.push_back(v(1, I_ADD, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2));
    tbl.push_back(v(1, I_ADD, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(v(1, I_ADD, 0, 1, 8, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, I_LW,  0, 1, 0, 1, 0, 0, 1, 1, 0, 0, 2, 0, 2, 0, 0));
    tbl.push_back(v(1, I_LW,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2));
    tbl.push_back(v(1, I_LW,  0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(v(1, I_LW,  0, 0, 3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, I_LW,  0, 0, 3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, I_LW,  0, 1, 3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, I_LW,  0, 1, 4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(1, I_BEQ, 1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 2, 0, 2, 0, 0));
    tbl.push_back(v(1, I_BEQ, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2));
    tbl.push_back(v(1, I_BEQ, 1, 1, 9, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 1, 0));
    tbl.push_back(v(1, I_BEQ, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0, 2, 0, 2, 0, 0));
    tbl.push_back(v(1, I_BEQ, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2));
    tbl.push_back(v(1, I_BEQ, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0));
    tbl.push_back(v(1, I_JALR, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0, 2, 0, 2, 0, 0));
    tbl.push_back(v(1, I_JALR, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2));
    tbl.push_back(v(1, I_JALR, 0, 1, 11, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(v(1, I_JALR, 0, 1, 12, 0, 0, 0, 0, 1, 1, 0, 0, 1, 2, 0, 0));
    tbl.push_back(v(1, I_JALR, 0, 1, 8, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, I_LUI, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0));
    tbl.push_back(v(1, I_LUI, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0, 2, 0, 2, 0, 0));
    tbl.push_back(v(1, I_LUI, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2));
    tbl.push_back(v(1, I_LUI, 0, 1, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 3));
    tbl.push_back(v(1, I_LUI, 0, 1, 8, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

    @(posedge clk_i); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      rst_ni = tbl[i].rst; instr_i = tbl[i].instr;
      zero_i = tbl[i].zero; mem_ready_i = tbl[i].ready;
      #1 check($sformatf("vec%0d", i), tbl[i].st, tbl[i].o);
      @(posedge clk_i); #1;
    end

    // Illegal opcode: TRAP holds with no strobes until reset
    instr_i = 32'hFFFF_FFFF; mem_ready_i = 1'b1; zero_i = 1'b0;
    #1 check("trap_fetch", 0, exp_out(0, instr_i, 1'b0, 1'b1));
    @(posedge clk_i); #1;
    #1 check("trap_decode", 1, exp_out(1, instr_i, 1'b0, 1'b1));
    @(posedge clk_i); #1;
    for (int i = 0; i < 12; i++) begin
      zero_i = 1'($urandom); mem_ready_i = 1'($urandom);
      #1 check("trap_hold", 15, exp_out(15, instr_i, zero_i, mem_ready_i));
      @(posedge clk_i); #1;
    end
    #2 rst_ni = 1'b0;
    #1 check("trap_reset", 0, rst_o);
    @(posedge clk_i); #1;
    check("trap_reset_hold", 0, rst_o);

    // Reset asserted in the middle of a FETCH wait
    rst_ni = 1'b1; mem_ready_i = 1'b0; instr_i = I_ADD;
    #1 check("first_req", 0, exp_out(0, I_ADD, 1'b0, 1'b0));
    @(posedge clk_i); #1;
    check("fetch_wait", 0, exp_out(0, I_ADD, 1'b0, 1'b0));
    #2 rst_ni = 1'b0;
    #1 check("rst_fetch_wait", 0, rst_o);
    @(posedge clk_i); #1;
    mem_ready_i = 1'b1;
    #1 check("rst_fetch_hold", 0, rst_o);
    rst_ni = 1'b1;

    // Reset asserted in the middle of a MEMREAD wait
    instr_i = I_LW;
    for (int s = 0; s < 3; s++) begin
      #1 check("lw_pre", 4'(s), exp_out(s, I_LW, 1'b0, 1'b1));
      @(posedge clk_i); #1;
    end
    mem_ready_i = 1'b0;
    #1 check("memread_wait", 3, exp_out(3, I_LW, 1'b0, 1'b0));
    #2 rst_ni = 1'b0;
    #1 check("rst_memread", 0, rst_o);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Randomized instructions against the per-class state path model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] w;
      int idx, guard, trap_cycles, st;
      w = gen_instr();
      fill_seq(class_of(w));
      idx = 0; guard = 0; trap_cycles = 0;
      instr_i = w;
      while (idx < seq.size()) begin
        st = seq[idx];
        zero_i = 1'($urandom);
        mem_ready_i = ($urandom_range(0, 2) != 0);
        #1 check($sformatf("rand%0d_%08h", n, w), 4'(st), exp_out(st, w, zero_i, mem_ready_i));
        if (st == 15) begin
          trap_cycles++;
          if (trap_cycles == 4) begin
            #1 rst_ni = 1'b0;
            #1 check("rand_trap_reset", 0, rst_o);
            @(posedge clk_i); #1;
            rst_ni = 1'b1;
            break;
          end
        end else if (!((st == 0 || st == 3 || st == 5) && !mem_ready_i)) begin
          idx++;
        end
        @(posedge clk_i); #1;
        guard++;
        if (guard > 200) begin
          n_checks++; n_fail++;
          $display("FAIL rand_budget: instr %08h exceeded 200 cycles, expected return to FETCH", w);
          break;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
